// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetches one 16-bit instruction word per request and strobes it into the IR
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] pc,
  input  logic        flush,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        ir_load,
  output logic [15:0] ir_data,
  output logic [15:0] pc_plus2,
  output logic        busy,
  output logic        misalign_err,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] addr_q;
  logic        mem_read_q;
  logic        ir_load_q;
  logic [15:0] ir_data_q;
  logic [15:0] pc_plus2_q;
  logic        busy_q;
  logic        misalign_q;
  logic        fetch_err_q;
  logic [7:0]  cnt_q;
  logic        discard_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'h0000;
      mem_read_q  <= 1'b0;
      ir_load_q   <= 1'b0;
      ir_data_q   <= 16'h0000;
      pc_plus2_q  <= 16'h0000;
      busy_q      <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      cnt_q       <= 8'd0;
      discard_q   <= 1'b0;
    end else begin
      ir_load_q   <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_req && !flush) begin
            if (pc[0]) begin
              misalign_q <= 1'b1;
            end else begin
              addr_q     <= pc;
              mem_read_q <= 1'b1;
              cnt_q      <= 8'd0;
              discard_q  <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A response always wins over the timeout, even on the last allowed cycle.
          if (mem_resp) begin
            mem_read_q <= 1'b0;
            discard_q  <= 1'b0;
            if (discard_q || flush) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              ir_data_q  <= mem_rdata;
              pc_plus2_q <= addr_q + 16'd2;
              ir_load_q  <= 1'b1;
              state_q    <= S_DONE;
            end
          end else if (cnt_q == LAST_WAIT) begin
            mem_read_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            discard_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (flush) begin
              discard_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_address  = addr_q;
  assign mem_read     = mem_read_q;
  // A flush arriving in the delivery cycle still suppresses the IR load.
  assign ir_load      = ir_load_q & ~flush;
  assign ir_data      = ir_data_q;
  assign pc_plus2     = pc_plus2_q;
  assign busy         = busy_q;
  assign misalign_err = misalign_q;
  assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit against a transaction-level model
module tb_instr_fetch_unit;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] pc;
  logic        flush;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        ir_load;
  logic [15:0] ir_data;
  logic [15:0] pc_plus2;
  logic        busy;
  logic        misalign_err;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_ir;
  logic [15:0] exp_pc2;

  instr_fetch_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .mem_address(mem_address), .mem_read(mem_read), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .ir_load(ir_load), .ir_data(ir_data), .pc_plus2(pc_plus2),
    .busy(busy), .misalign_err(misalign_err), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp_v);
  endtask

  // lat >= TO means memory never answers; flush_at < 0 means no flush during WAIT.
  task automatic run_fetch(input logic [15:0] a, input int lat, input logic [15:0] d,
                           input int flush_at, input bit flush_done);
    bit timed_out;
    bit dropped;
    timed_out = (lat >= TO);
    dropped   = !timed_out && (flush_at >= 0) && (flush_at <= lat);
    fetch_req = 1'b1;
    pc        = a;
    step();
    fetch_req = 1'b0;
    chk1("acc_read", mem_read, 1'b1);
    chk16("acc_addr", mem_address, a);
    chk1("acc_busy", busy, 1'b1);
    for (int k = 0; k < TO; k++) begin
      flush     = (k == flush_at);
      mem_resp  = (k == lat);
      mem_rdata = (k == lat) ? d : 16'($urandom);
      step();
      flush    = 1'b0;
      mem_resp = 1'b0;
      if (k == lat) break;
      if (k < TO - 1) begin
        chk1("wait_read", mem_read, 1'b1);
        chk16("wait_addr", mem_address, a);
      end
    end
    if (timed_out) begin
      chk1("to_err", fetch_err, 1'b1);
      chk1("to_read", mem_read, 1'b0);
      chk1("to_busy", busy, 1'b0);
      chk1("to_load", ir_load, 1'b0);
      step();
      chk1("to_pulse", fetch_err, 1'b0);
    end else if (dropped) begin
      chk1("drop_load", ir_load, 1'b0);
      chk1("drop_read", mem_read, 1'b0);
      chk1("drop_busy", busy, 1'b0);
      chk16("drop_ir", ir_data, exp_ir);
      step();
      chk1("drop_load2", ir_load, 1'b0);
      chk16("drop_ir2", ir_data, exp_ir);
    end else begin
      if (flush_done) begin
        flush = 1'b1;
        #1;
      end
      chk1("done_load", ir_load, !flush_done);
      chk1("done_read", mem_read, 1'b0);
      chk1("done_err", fetch_err, 1'b0);
      chk1("done_busy", busy, 1'b1);
      if (!flush_done) begin
        exp_ir  = d;
        exp_pc2 = a + 16'd2;
        chk16("done_ir", ir_data, exp_ir);
        chk16("done_pc2", pc_plus2, exp_pc2);
      end
      step();
      flush = 1'b0;
      chk1("post_load", ir_load, 1'b0);
      chk1("post_busy", busy, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] drv;
    logic [15:0] ra;
    int          rl;
    int          rf;

    rst_n = 1'b0; fetch_req = 1'b0; pc = 16'h0000; flush = 1'b0;
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    exp_ir = 16'h0000; exp_pc2 = 16'h0000;
    step();
    chk1("rst_read", mem_read, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_load", ir_load, 1'b0);
    chk16("rst_ir", ir_data, 16'h0000);
    chk16("rst_pc2", pc_plus2, 16'h0000);
    chk16("rst_addr", mem_address, 16'h0000);
    rst_n = 1'b1;
    step();

    run_fetch(16'h1000, 3, 16'h1283, -1, 1'b0);

    fetch_req = 1'b1; pc = 16'h2001;
    step();
    fetch_req = 1'b0;
    chk1("mis_err", misalign_err, 1'b1);
    chk1("mis_read", mem_read, 1'b0);
    chk1("mis_busy", busy, 1'b0);
    step();
    chk1("mis_pulse", misalign_err, 1'b0);
    chk1("mis_busy2", busy, 1'b0);

    fetch_req = 1'b1; flush = 1'b1; pc = 16'h2200;
    step();
    fetch_req = 1'b0; flush = 1'b0;
    chk1("reqflush_busy", busy, 1'b0);
    chk1("reqflush_read", mem_read, 1'b0);

    run_fetch(16'h2400, 3, 16'hF025, 1, 1'b0);

    run_fetch(16'h4000, TO, 16'hDEAD, -1, 1'b0);
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_resp = 1'b0;
    chk1("late_load", ir_load, 1'b0);
    chk1("late_busy", busy, 1'b0);
    chk16("late_ir", ir_data, exp_ir);
    run_fetch(16'h4002, 1, 16'h5A5A, -1, 1'b0);

    run_fetch(16'h5000, TO - 1, 16'h1234, -1, 1'b0);
    run_fetch(16'h5100, TO, 16'h0000, 5, 1'b0);
    run_fetch(16'h5200, 2, 16'h7777, -1, 1'b1);
    run_fetch(16'h5300, 0, 16'h8888, -1, 1'b0);

    for (int n = 0; n < 10; n++) begin
      ra = 16'($urandom) & 16'hFFFE;
      rl = int'($urandom_range(0, 6));
      rf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_fetch(ra, rl, 16'($urandom), rf, 1'b0);
    end

    fetch_req = 1'b1; pc = 16'h3000; mem_resp = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drv = 16'($urandom);
      mem_rdata = drv;
      step();
      chk1("zw_read", mem_read, (i % 3 == 1));
      if (i % 3 == 2) begin
        chk1("zw_load", ir_load, 1'b1);
        chk16("zw_ir", ir_data, drv);
        chk16("zw_pc2", pc_plus2, 16'h3002);
        exp_ir  = drv;
        exp_pc2 = 16'h3002;
      end else begin
        chk1("zw_noload", ir_load, 1'b0);
      end
    end
    fetch_req = 1'b0; mem_resp = 1'b0;
    step();
    chk1("zw_idle", busy, 1'b0);

    run_fetch(16'hFFFE, 2, 16'h0FFF, -1, 1'b0);

    fetch_req = 1'b1; pc = 16'h6000;
    step();
    fetch_req = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_read", mem_read, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk16("arst_ir", ir_data, 16'h0000);
    chk16("arst_pc2", pc_plus2, 16'h0000);
    step();
    rst_n = 1'b1;
    exp_ir = 16'h0000; exp_pc2 = 16'h0000;
    step();
    run_fetch(16'h7000, 4, 16'hA55A, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
